mmio_io_bridge: RTL and testbench
=================================

Name: mmio_io_bridge

Overview:
- Parametrised successor to the single-cycle CPU's data-bus bridge.
- Decodes each CPU data access either to the data DRAM (passed through combinationally) or to an I/O register file in the 0xFFFFF000 page.
- I/O registers: 7-seg data, free-running timer, LED (write/set/clear), synchronised switches, debounced buttons with sticky edge flags.
- Sits between the CPU data port and the dram IP / board pins.

Parameters:
- DRAM_BASE, 32'h0000_4000, byte address mapped to DRAM word 0
- DRAM_AW, 14, DRAM word-address width
- SW_W, 24, switch count (≤32)
- LED_W, 24, LED count (≤32)
- BTN_W, 5, button count (≤32)
- DEB_CYC, 20'd1_000_000, cycles a button must hold stable before its debounced level changes (≥2)

Ports:
- clk  in  1  system clock; all registers rise-edge
- rst  in  1  synchronous active-high reset
- addr  in  32  CPU byte address
- wen  in  1  CPU write strobe
- wdata  in  32  CPU write data
- rdata  out  32  CPU read data (combinational)
- dram_addr  out  DRAM_AW  word address to dram
- dram_we  out  1  dram write enable
- dram_wdata  out  32  equals wdata
- dram_rdata  in  32  dram spo
- device_sw  in  SW_W  raw switches (asynchronous)
- device_button  in  BTN_W  raw buttons (asynchronous, bouncing)
- device_led  out  LED_W  LED register
- led_data  out  32  7-seg display register

Behaviour:
- Decode: io_hit = (addr[31:12] == 20'hFFFFF); offset = addr[11:0]. Only offsets listed below are mapped.
- DRAM path: dram_addr = (addr − DRAM_BASE)[DRAM_AW+1:2]; dram_we = wen & ~io_hit. An I/O access never writes DRAM.
- Register map (offset, access, meaning):
  - 0x000 RW: SEG. Write loads led_data = wdata.
  - 0x020 RW: TIMER. Increments by 1 every cycle and wraps at 2^32. A write loads wdata and suppresses that cycle's increment, so TIMER = wdata on the next cycle, then wdata+1.
  - 0x060 RW: LED = wdata[LED_W-1:0].
  - 0x064 W: LED |= wdata. Reads return LED.
  - 0x068 W: LED &= ~wdata. Reads return LED.
  - 0x070 R: {0, sw_sync}.
  - 0x078 R: {0, btn_deb}.
  - 0x07C R/W1C: {0, btn_edge}.
  - Unmapped I/O offsets read 0; writes are ignored.
- I/O writes take effect at the next clk rising edge. Reads are combinational from the current register value.
- rdata = dram_rdata when ~io_hit, else the mapped register value (zero-extended).
- Switch path: 2-flop synchroniser per bit. sw_sync lags device_sw by 2 cycles.
- Button path, per bit:
  - 2-flop synchroniser, then a counter of width $clog2(DEB_CYC).
  - While the synced bit ≠ btn_deb, the counter increments. When it reaches DEB_CYC−1, btn_deb takes the synced value and the counter clears.
  - Any cycle where the synced bit = btn_deb clears the counter (a glitch restarts the count).
- btn_edge[i] sets on a 0→1 transition of btn_deb[i] and stays set until W1C.
  - If a set and a W1C of the same bit coincide, set wins.
  - A W1C with a 0 bit leaves that flag unchanged.
- Reset values: led_data = 0, device_led = 0, TIMER = 0; synchronisers, btn_deb, btn_edge and all debounce counters = 0.
- Reset mid-debounce discards the partial count.
- wen with addr outside both DRAM and I/O ranges still asserts dram_we; the address wraps modulo the DRAM size (same as the single-cycle convention).

Decomposition:
- Shared package mmio_pkg holds:
  - IO_PAGE = 20'hFFFFF
  - the offset localparams: OFF_SEG, OFF_TIMER, OFF_LED, OFF_LED_SET, OFF_LED_CLR, OFF_SW, OFF_BTN, OFF_BTN_EDGE
- One sub-module, btn_debounce (1 bit, parameter DEB_CYC): synchroniser, counter, debounced level, rise pulse. Instantiated BTN_W times via generate.
- Switch synchroniser, register file and decode stay inline.

Test Plan:
- Reset, then read 0x070/0x078/0x07C/0x000 → all 0; device_led = 0; TIMER reads 0 then 1, 2, … on successive cycles.
- Write 0x060 = 0x00F0F0, then 0x064 = 0x000001, then 0x068 = 0x0000F0 → device_led 0x00F0F0, 0x00F0F1, 0x00F001; no dram_we pulse on any of these writes.
- DRAM access: write addr 0x4008 with data 0xDEADBEEF → dram_addr = 2, dram_we = 1; read addr 0x4008 returns dram_rdata; write addr 0xFFFFF044 (unmapped) → dram_we = 0, reads return 0.
- DEB_CYC = 4: button[0] bounces 1,0,1 on single cycles → btn_deb stays 0. Button held 1 → btn_deb = 1 after 2 sync + 4 count cycles and btn_edge[0] = 1. Write 0x07C = 1 → flag clears. Write 0x07C = 1 on the same cycle as a new rise → flag stays 1.
- Write TIMER = 0xFFFFFFFE → reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. Assert rst mid-count → next read 0.
- device_sw = 0xABCDEF → 0x070 reads 0xABCDEF exactly 2 cycles later. Write SEG 0x12345678 → led_data = 0x12345678 next cycle.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - I/O page and register offsets shared by the MMIO bridge
package mmio_pkg;

  localparam logic [19:0] IO_PAGE      = 20'hFFFFF;

  localparam logic [11:0] OFF_SEG      = 12'h000;
  localparam logic [11:0] OFF_TIMER    = 12'h020;
  localparam logic [11:0] OFF_LED      = 12'h060;
  localparam logic [11:0] OFF_LED_SET  = 12'h064;
  localparam logic [11:0] OFF_LED_CLR  = 12'h068;
  localparam logic [11:0] OFF_SW       = 12'h070;
  localparam logic [11:0] OFF_BTN      = 12'h078;
  localparam logic [11:0] OFF_BTN_EDGE = 12'h07C;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-bit button synchroniser and debouncer with rise pulse
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_deb,
  output logic btn_rise
);

  localparam int CW = $clog2(DEB_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          settle;

  // The debounced level flips on the cycle the mismatch count completes.
  assign settle   = (s2 != btn_deb) && (cnt == CNT_MAX);
  assign btn_rise = settle && s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      btn_deb <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if ((s2 == btn_deb) || settle) cnt <= '0;
      else                           cnt <= cnt + CW'(1);
      if (settle) btn_deb <= s2;
    end
  end

endmodule

// File: rtl/mmio_io_bridge.sv
// rtl/mmio_io_bridge.sv - CPU data-bus bridge: DRAM pass-through plus I/O register page
module mmio_io_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE = 32'h0000_4000,
  parameter int          DRAM_AW   = 14,
  parameter int          SW_W      = 24,
  parameter int          LED_W     = 24,
  parameter int          BTN_W     = 5,
  parameter int          DEB_CYC   = 20'd1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic               wen,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [SW_W-1:0]    device_sw,
  input  logic [BTN_W-1:0]   device_button,
  output logic [LED_W-1:0]   device_led,
  output logic [31:0]        led_data
);

  logic             io_hit;
  logic [11:0]      offset;
  logic             io_wr;
  logic [31:0]      timer;
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_sync;
  logic [BTN_W-1:0] btn_deb;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] btn_edge;
  logic [BTN_W-1:0] edge_clr;

  assign io_hit     = (addr[31:12] == IO_PAGE);
  assign offset     = addr[11:0];
  assign io_wr      = wen & io_hit;

  // Addresses outside the DRAM window wrap modulo the DRAM size.
  assign dram_addr  = DRAM_AW'((addr - DRAM_BASE) >> 2);
  assign dram_we    = wen & ~io_hit;
  assign dram_wdata = wdata;
  assign device_led = led;

  assign edge_clr   = (io_wr && (offset == OFF_BTN_EDGE)) ? wdata[BTN_W-1:0] : '0;

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (device_button[i]),
      .btn_deb  (btn_deb[i]),
      .btn_rise (btn_rise[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1    <= '0;
      sw_sync  <= '0;
      timer    <= '0;
      led      <= '0;
      led_data <= '0;
      btn_edge <= '0;
    end else begin
      sw_s1   <= device_sw;
      sw_sync <= sw_s1;
      timer   <= (io_wr && (offset == OFF_TIMER)) ? wdata : timer + 32'd1;
      if (io_wr) begin
        case (offset)
          OFF_SEG:     led_data <= wdata;
          OFF_LED:     led      <= wdata[LED_W-1:0];
          OFF_LED_SET: led      <= led | wdata[LED_W-1:0];
          OFF_LED_CLR: led      <= led & ~wdata[LED_W-1:0];
          default: begin end
        endcase
      end
      // A new rise outranks a simultaneous write-one-to-clear.
      btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
    end
  end

  always_comb begin
    rdata = dram_rdata;
    if (io_hit) begin
      case (offset)
        OFF_SEG:                          rdata = led_data;
        OFF_TIMER:                        rdata = timer;
        OFF_LED, OFF_LED_SET, OFF_LED_CLR: rdata = 32'(led);
        OFF_SW:                           rdata = 32'(sw_sync);
        OFF_BTN:                          rdata = 32'(btn_deb);
        OFF_BTN_EDGE:                     rdata = 32'(btn_edge);
        default:                          rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb/tb_mmio_io_bridge.sv - self-checking bench for mmio_io_bridge
module tb_mmio_io_bridge;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] device_sw;
  logic [4:0]  device_button;
  logic [23:0] device_led;
  logic [31:0] led_data;

  always #5 clk = ~clk;

  mmio_io_bridge #(
    .DRAM_BASE(32'h0000_4000), .DRAM_AW(14), .SW_W(24), .LED_W(24), .BTN_W(5), .DEB_CYC(DEB)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .device_sw(device_sw), .device_button(device_button), .device_led(device_led),
    .led_data(led_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [11:0] off, input logic [31:0] d);
    addr = {20'hFFFFF, off}; wen = 1'b1; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [11:0] off, input logic [31:0] exp);
    addr = {20'hFFFFF, off}; wen = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  function automatic logic [31:0] exp_daddr(input logic [31:0] a);
    return ((a - 32'h4000) >> 2) % 32'h4000;
  endfunction

  // Reference model: register values as seen between clock edges.
  logic [31:0] m_seg, m_timer;
  logic [23:0] m_led, m_sw;
  logic [4:0]  m_deb, m_edge, m_bsync;
  logic [23:0] sw_q[$];
  logic [4:0]  btn_q[$];
  logic [4:0]  hist[$];

  task automatic model_reset();
    m_seg = '0; m_timer = '0; m_led = '0; m_sw = '0;
    m_deb = '0; m_edge = '0; m_bsync = '0;
    sw_q = {}; btn_q = {}; hist = {};
    sw_q.push_back('0);
    btn_q.push_back('0);
    for (int k = 0; k < DEB; k++) hist.push_back('0);
  endtask

  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [23:0] sw, input logic [4:0] btn);
    logic       io;
    logic [4:0] rise;
    logic       all_diff;
    io = (a[31:12] == 20'hFFFFF);
    hist.push_back(m_bsync);
    void'(hist.pop_front());
    rise = '0;
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_deb[b] = ~m_deb[b];
        if (m_deb[b]) rise[b] = 1'b1;
      end
    end
    m_bsync = btn_q.pop_front(); btn_q.push_back(btn);
    m_sw    = sw_q.pop_front();  sw_q.push_back(sw);
    if (w && io && a[11:0] == 12'h07C) m_edge = m_edge & ~d[4:0];
    m_edge  = m_edge | rise;
    m_timer = (w && io && a[11:0] == 12'h020) ? d : m_timer + 1;
    if (w && io) begin
      case (a[11:0])
        12'h000: m_seg = d;
        12'h060: m_led = d[23:0];
        12'h064: m_led = m_led | d[23:0];
        12'h068: m_led = m_led & ~d[23:0];
        default: begin end
      endcase
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] dr);
    if (a[31:12] != 20'hFFFFF) return dr;
    case (a[11:0])
      12'h000:                   return m_seg;
      12'h020:                   return m_timer;
      12'h060, 12'h064, 12'h068: return {8'h0, m_led};
      12'h070:                   return {8'h0, m_sw};
      12'h078:                   return {27'h0, m_deb};
      12'h07C:                   return {27'h0, m_edge};
      default:                   return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] dr;
    logic        ewe;
    logic        chk_rd;
    logic [31:0] erd;
    logic [31:0] eled;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] ra, rd, rdr;
    logic        rw;
    logic [23:0] rsw;
    logic [4:0]  rbtn;

    vt[0]  = '{32'hFFFFF060, 1'b1, 32'h0000F0F0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00F0F0};
    vt[1]  = '{32'hFFFFF060, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0000F0F0, 32'h00F0F0};
    vt[2]  = '{32'hFFFFF064, 1'b1, 32'h00000001, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00F0F1};
    vt[3]  = '{32'hFFFFF064, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0000F0F1, 32'h00F0F1};
    vt[4]  = '{32'hFFFFF068, 1'b1, 32'h000000F0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00F001};
    vt[5]  = '{32'hFFFFF068, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0000F001, 32'h00F001};
    vt[6]  = '{32'h00004008, 1'b1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 32'h0,        32'h00F001};
    vt[7]  = '{32'h00004008, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 32'h00F001};
    vt[8]  = '{32'hFFFFF044, 1'b1, 32'h00000055, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00F001};
    vt[9]  = '{32'hFFFFF044, 1'b0, 32'h0,        32'h11111111, 1'b0, 1'b1, 32'h0,        32'h00F001};
    vt[10] = '{32'h00000010, 1'b1, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0,        32'h00F001};
    vt[11] = '{32'hFFFFF060, 1'b1, 32'hFF123456, 32'h0,        1'b0, 1'b0, 32'h0,        32'h123456};
    vt[12] = '{32'hFFFFF060, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00123456, 32'h123456};
    vt[13] = '{32'hFFFFF800, 1'b0, 32'h0,        32'h77777777, 1'b0, 1'b1, 32'h0,        32'h123456};

    rst = 1'b1; addr = '0; wen = 1'b0; wdata = '0; dram_rdata = '0;
    device_sw = '0; device_button = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_rd("timer_after_reset", 12'h020, 32'd0);
    tick(); check_rd("timer_plus1", 12'h020, 32'd1);
    tick(); check_rd("timer_plus2", 12'h020, 32'd2);
    check_rd("reset_sw", 12'h070, 32'h0);
    check_rd("reset_btn", 12'h078, 32'h0);
    check_rd("reset_edge", 12'h07C, 32'h0);
    check_rd("reset_seg", 12'h000, 32'h0);
    check("reset_device_led", device_led, 32'h0);
    tick();

    for (int i = 0; i < 14; i++) begin
      addr = vt[i].a; wen = vt[i].w; wdata = vt[i].d; dram_rdata = vt[i].dr;
      #1;
      check($sformatf("vec%0d dram_we", i), dram_we, vt[i].ewe);
      check($sformatf("vec%0d dram_addr", i), dram_addr, exp_daddr(vt[i].a));
      check($sformatf("vec%0d dram_wdata", i), dram_wdata, vt[i].d);
      if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), rdata, vt[i].erd);
      tick();
      wen = 1'b0;
      check($sformatf("vec%0d device_led", i), device_led, vt[i].eled);
    end

    device_sw = 24'hABCDEF;
    check_rd("sw_lag0", 12'h070, 32'h0);
    tick(); check_rd("sw_lag1", 12'h070, 32'h0);
    tick(); check_rd("sw_lag2", 12'h070, 32'h00ABCDEF);

    io_write(12'h000, 32'h12345678);
    check("seg_led_data", led_data, 32'h12345678);
    check_rd("seg_read", 12'h000, 32'h12345678);

    device_button = 5'b00001; tick();
    device_button = 5'b00000; tick();
    device_button = 5'b00001; tick();
    device_button = 5'b00000;
    repeat (8) tick();
    check_rd("bounce_deb", 12'h078, 32'h0);
    check_rd("bounce_edge", 12'h07C, 32'h0);

    device_button = 5'b00001;
    repeat (5) tick();
    check_rd("hold_deb_early", 12'h078, 32'h0);
    tick();
    check_rd("hold_deb", 12'h078, 32'h1);
    check_rd("hold_edge", 12'h07C, 32'h1);
    io_write(12'h07C, 32'h0);
    check_rd("w1c_zero_keeps", 12'h07C, 32'h1);
    io_write(12'h07C, 32'h1);
    check_rd("w1c_clears", 12'h07C, 32'h0);

    device_button = 5'b00000;
    repeat (8) tick();
    check_rd("release_deb", 12'h078, 32'h0);
    check_rd("release_no_edge", 12'h07C, 32'h0);

    device_button = 5'b00001;
    repeat (5) tick();
    io_write(12'h07C, 32'h1);
    check_rd("coincide_deb", 12'h078, 32'h1);
    check_rd("coincide_set_wins", 12'h07C, 32'h1);

    io_write(12'h020, 32'hFFFFFFFE);
    check_rd("timer_load", 12'h020, 32'hFFFFFFFE);
    tick(); check_rd("timer_ff", 12'h020, 32'hFFFFFFFF);
    tick(); check_rd("timer_wrap", 12'h020, 32'h0);

    device_button = 5'b00011;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_rd("timer_rst", 12'h020, 32'h0);
    check_rd("deb_rst", 12'h078, 32'h0);
    check_rd("edge_rst", 12'h07C, 32'h0);
    repeat (5) tick();
    check_rd("deb_restart_early", 12'h078, 32'h0);
    tick();
    check_rd("deb_restart", 12'h078, 32'h3);
    check_rd("edge_restart", 12'h07C, 32'h3);

    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    rbtn = device_button;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'hFFFFF000;
        1: ra = 32'hFFFFF020;
        2: ra = 32'hFFFFF060;
        3: ra = 32'hFFFFF064;
        4: ra = 32'hFFFFF068;
        5: ra = 32'hFFFFF070;
        6: ra = 32'hFFFFF078;
        7: ra = 32'hFFFFF07C;
        8: ra = {20'hFFFFF, 12'($urandom_range(0, 1023)) << 2};
        default: ra = $urandom;
      endcase
      rw  = ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      rdr = $urandom;
      rsw = 24'($urandom);
      if ($urandom_range(0, 5) == 0) rbtn = rbtn ^ (5'b1 << $urandom_range(0, 4));
      addr = ra; wen = rw; wdata = rd; dram_rdata = rdr;
      device_sw = rsw; device_button = rbtn;
      #1;
      check($sformatf("rand%0d rdata @%h", n, ra), rdata, model_read(ra, rdr));
      check($sformatf("rand%0d dram_we", n), dram_we, rw & (ra[31:12] != 20'hFFFFF));
      check($sformatf("rand%0d dram_addr", n), dram_addr, exp_daddr(ra));
      check($sformatf("rand%0d device_led", n), device_led, m_led);
      check($sformatf("rand%0d led_data", n), led_data, m_seg);
      @(posedge clk);
      model_step(ra, rw, rd, rsw, rbtn);
      #1;
    end
    wen = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
